// File: rtl/river_cfg_pkg.sv
// -----------------------------------------------------------------------------
// river_cfg_pkg
// Core-wide configuration constants shared by the River CPU blocks.
//   RISCV_ARCH            : integer register / pc width in bits
//   STACK_TRACE_BUF_SIZE  : number of entries in the stack trace buffer
// -----------------------------------------------------------------------------
package river_cfg_pkg;

   localparam int RISCV_ARCH           = 64;
   localparam int STACK_TRACE_BUF_SIZE = 32;

endpackage : river_cfg_pkg

// File: rtl/stacktr_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// stacktr_ctrl_pkg
// Types and constants for the stack trace buffer write-side controller.
//   STACKTR_ABITS          : buffer address width
//   STACKTR_XLEN           : pc / npc width
//   DEPTH                  : number of buffer entries (2**STACKTR_ABITS)
//   stacktr_ctrl_registers : complete register state of stacktr_ctrl
//   stacktr_ctrl_r_reset   : value of that state after reset
// -----------------------------------------------------------------------------
package stacktr_ctrl_pkg;

   import river_cfg_pkg::*;

   localparam int STACKTR_ABITS = $clog2(STACK_TRACE_BUF_SIZE);
   localparam int STACKTR_XLEN  = RISCV_ARCH;
   localparam int DEPTH         = 2 ** STACKTR_ABITS;

   typedef struct packed {
      logic [STACKTR_ABITS:0]      cnt;    // valid entries, 0..DEPTH
      logic [STACKTR_ABITS-1:0]    wptr;   // next write slot
      logic                        ovf;    // sticky: trace lost entries
      logic                        we;     // write strobe to the buffer
      logic [STACKTR_ABITS-1:0]    waddr;  // write address to the buffer
      logic [2*STACKTR_XLEN-1:0]   wdata;  // {pc, npc}
   } stacktr_ctrl_registers;

   localparam stacktr_ctrl_registers stacktr_ctrl_r_reset = '{
      cnt:   '0,
      wptr:  '0,
      ovf:   1'b0,
      we:    1'b0,
      waddr: '0,
      wdata: '0
   };

endpackage : stacktr_ctrl_pkg

// File: rtl/stacktr_ctrl.sv
// -----------------------------------------------------------------------------
// stacktr_ctrl
// Write-side controller of the stack trace buffer. Tracks retired calls and
// returns, keeps the stack depth and write pointer, and issues one registered
// write of {pc, npc} per call. Depth and a sticky overflow flag go to the
// debug port so the debugger knows how many buffer entries are valid.
//
// Configuration macro:
//   RIVER_STACKTR_WRAP_EN  defined   : a call when full overwrites the oldest
//                                      entry (circular trace), sets ovf.
//                          undefined : a call when full is dropped (saturate),
//                                      sets ovf.
//
// Parameters (must match the widths in stacktr_ctrl_pkg, which sizes the
// register struct):
//   abits  buffer address width, DEPTH = 2**abits
//   xlen   pc / npc width
//
// Ports:
//   i_clk      core clock
//   i_rst      synchronous reset, active-high
//   i_e_valid  executor retired an instruction this cycle
//   i_e_pc     pc of the retired instruction
//   i_e_npc    next pc (call target)
//   i_e_call   retired instruction is a call
//   i_e_ret    retired instruction is a return
//   i_clr      debug request to empty the trace
//   o_we       buffer write strobe (one-cycle pulse)
//   o_waddr    buffer write address
//   o_wdata    buffer write data {pc, npc}, pc in the upper half
//   o_cnt      number of valid entries, 0..DEPTH
//   o_wptr     next write slot; top entry is at o_wptr-1
//   o_ovf      sticky overflow flag
// -----------------------------------------------------------------------------
module stacktr_ctrl
   import stacktr_ctrl_pkg::*;
#(
   parameter int abits = STACKTR_ABITS,
   parameter int xlen  = STACKTR_XLEN
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_e_valid,
   input  logic [xlen-1:0]   i_e_pc,
   input  logic [xlen-1:0]   i_e_npc,
   input  logic              i_e_call,
   input  logic              i_e_ret,
   input  logic              i_clr,
   output logic              o_we,
   output logic [abits-1:0]  o_waddr,
   output logic [2*xlen-1:0] o_wdata,
   output logic [abits:0]    o_cnt,
   output logic [abits-1:0]  o_wptr,
   output logic              o_ovf
);

   localparam logic [abits:0] full_cnt = (abits + 1)'(DEPTH);

   stacktr_ctrl_registers r;
   stacktr_ctrl_registers rin;

   logic is_call;
   logic is_ret;
   logic empty;
   logic full;

   assign is_call = i_e_valid & i_e_call;
   assign is_ret  = i_e_valid & i_e_ret;
   assign empty   = (r.cnt == '0);
   assign full    = (r.cnt == full_cnt);

   always_comb begin
      // NOTE: start from the current state so every field has a value on
      // every path; combinational blocks use blocking '=' and infer no latch.
      rin    = r;
      rin.we = 1'b0;   // strobe is a single-cycle pulse

      if (i_clr) begin
         // Clear wins over any event retired in the same cycle.
         rin.cnt  = '0;
         rin.wptr = '0;
         rin.ovf  = 1'b0;
      end else if (is_call && is_ret && !empty) begin
         // Coroutine jump: pop then push replaces the top entry in place.
         rin.we    = 1'b1;
         rin.waddr = r.wptr - 1'b1;
         rin.wdata = {i_e_pc, i_e_npc};
      end else if (is_call) begin
         // Also covers call+ret at cnt==0, which behaves as a plain call.
         if (!full) begin
            rin.we    = 1'b1;
            rin.waddr = r.wptr;
            rin.wdata = {i_e_pc, i_e_npc};
            rin.wptr  = r.wptr + 1'b1;
            rin.cnt   = r.cnt + 1'b1;
         end else begin
            rin.ovf = 1'b1;
`ifdef RIVER_STACKTR_WRAP_EN
            // Overwrite the oldest entry; depth stays saturated at DEPTH.
            rin.we    = 1'b1;
            rin.waddr = r.wptr;
            rin.wdata = {i_e_pc, i_e_npc};
            rin.wptr  = r.wptr + 1'b1;
`endif
         end
      end else if (is_ret && !empty) begin
         rin.wptr = r.wptr - 1'b1;
         rin.cnt  = r.cnt - 1'b1;
      end
   end

   // NOTE: state is updated with non-blocking '<=' so all fields change
   // together at the clock edge.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r <= stacktr_ctrl_r_reset;
      end else begin
         r <= rin;
      end
   end

   assign o_we    = r.we;
   assign o_waddr = r.waddr;
   assign o_wdata = r.wdata;
   assign o_cnt   = r.cnt;
   assign o_wptr  = r.wptr;
   assign o_ovf   = r.ovf;

endmodule : stacktr_ctrl
